// File: rtl/cache_lru_tree.sv
`default_nettype none
// ============================================================================
// Module      : cache_lru_tree
// Description : Tree pseudo-LRU replacement state for a set-associative cache.
//               Optional same-set write-to-read forwarding: CACHE_LRU_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_lru_tree #(
    parameter  int NUM_WAYS     = 4,
    parameter  int NUM_SETS     = 16,
    localparam int NUM_WAYS_LOG = $clog2(NUM_WAYS),
    localparam int NUM_SETS_LOG = $clog2(NUM_SETS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic                    init_done,
    input  logic                    access_en,
    input  logic [NUM_SETS_LOG-1:0] access_set,
    input  logic                    update_en,
    input  logic [NUM_WAYS_LOG-1:0] update_way_idx,
    input  logic                    fill_en,
    input  logic [NUM_SETS_LOG-1:0] fill_set,
    output logic [NUM_WAYS_LOG-1:0] fill_way_idx
);

    localparam int c_NUM_NODES = NUM_WAYS - 1;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Flags are padded to NUM_WAYS bits so a NUM_WAYS_LOG-bit node index
    // exactly spans the vector; the top bit is never a real node.
    function automatic logic [NUM_WAYS_LOG-1:0] plru_victim(
        input logic [c_NUM_NODES-1:0] flags
    );
        logic [NUM_WAYS-1:0]     f;
        logic [NUM_WAYS_LOG-1:0] node;
        logic [NUM_WAYS_LOG-1:0] way;
        logic                    b;
        f    = {1'b0, flags};
        node = '0;
        way  = '0;
        for (int lvl = 0; lvl < NUM_WAYS_LOG; lvl++) begin
            b    = f[node];
            way  = (way << 1) | NUM_WAYS_LOG'(b);
            node = NUM_WAYS_LOG'((32'(node) << 1) + 32'd1 + 32'(b));
        end
        return way;
    endfunction

    function automatic logic [c_NUM_NODES-1:0] plru_touch(
        input logic [c_NUM_NODES-1:0]  flags,
        input logic [NUM_WAYS_LOG-1:0] way
    );
        logic [NUM_WAYS-1:0]     f;
        logic [NUM_WAYS_LOG-1:0] node;
        logic [NUM_WAYS_LOG-1:0] w;
        logic                    b;
        f    = {1'b0, flags};
        node = '0;
        w    = way;
        for (int lvl = 0; lvl < NUM_WAYS_LOG; lvl++) begin
            b       = w[NUM_WAYS_LOG-1];
            f[node] = ~b;
            w       = w << 1;
            node    = NUM_WAYS_LOG'((32'(node) << 1) + 32'd1 + 32'(b));
        end
        return f[c_NUM_NODES-1:0];
    endfunction

    logic [c_NUM_NODES-1:0]  r_mem [NUM_SETS];

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [NUM_SETS_LOG-1:0] r_init_cnt;
    logic                    r_init_done;
    logic                    r_pend_fill;
    logic [NUM_SETS_LOG-1:0] r_wr_set;
    logic [c_NUM_NODES-1:0]  r_rd_flags;
    logic [NUM_WAYS_LOG-1:0] r_fill_way;

    logic                    w_init_last;
    logic                    w_run;
    logic                    w_rd_en;
    logic [NUM_SETS_LOG-1:0] w_rd_set;
    logic [c_NUM_NODES-1:0]  w_rd_flags;
    logic                    w_wr_en;
    logic [NUM_WAYS_LOG-1:0] w_touch_way;
    logic [c_NUM_NODES-1:0]  w_wr_flags;

    always_comb begin
        w_state_nxt = r_state;
        w_init_last = (r_init_cnt == NUM_SETS_LOG'(NUM_SETS - 1));
        case (r_state)
            ST_INIT: if (w_init_last) w_state_nxt = ST_RUN;
            ST_RUN:  w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_INIT;
        endcase
    end

    always_comb begin
        w_run       = (r_state == ST_RUN);
        w_rd_en     = w_run & (access_en | fill_en);
        w_rd_set    = fill_en ? fill_set : access_set;
        // A pending fill owns the write slot; update_en is dropped then.
        w_wr_en     = w_run & (r_pend_fill | update_en);
        w_touch_way = r_pend_fill ? r_fill_way : update_way_idx;
        w_wr_flags  = plru_touch(r_rd_flags, w_touch_way);
    end

`ifdef CACHE_LRU_BYPASS_EN
    assign w_rd_flags = (w_wr_en && (w_rd_set == r_wr_set)) ? w_wr_flags : r_mem[w_rd_set];
`else
    assign w_rd_flags = r_mem[w_rd_set];
`endif

    always_ff @(posedge clk) begin
        if (r_state == ST_INIT) begin
            r_mem[r_init_cnt] <= '0;
        end else if (w_wr_en) begin
            r_mem[r_wr_set] <= w_wr_flags;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_INIT;
            r_init_cnt  <= '0;
            r_init_done <= 1'b0;
            r_pend_fill <= 1'b0;
            r_wr_set    <= '0;
            r_rd_flags  <= '0;
            r_fill_way  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_init_done <= (w_state_nxt == ST_RUN);
            r_pend_fill <= w_rd_en & fill_en;
            if (r_state == ST_INIT) begin
                r_init_cnt <= r_init_cnt + NUM_SETS_LOG'(1);
            end
            // Victim is computed for every lookup, so an access also exposes it.
            if (w_rd_en) begin
                r_rd_flags <= w_rd_flags;
                r_wr_set   <= w_rd_set;
                r_fill_way <= plru_victim(w_rd_flags);
            end
        end
    end

    assign init_done    = r_init_done;
    assign fill_way_idx = r_fill_way;

endmodule
`default_nettype wire

// File: tb/tb_cache_lru_tree.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_lru_tree
// Description : Self-checking bench for cache_lru_tree against a range-based
//               tree-PLRU reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_lru_tree;

    localparam int NUM_WAYS = 4;
    localparam int NUM_SETS = 16;
    localparam int WL       = 2;
    localparam int SL       = 4;
    localparam int NODES    = NUM_WAYS - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          init_done;
    logic          access_en = 1'b0;
    logic [SL-1:0] access_set = '0;
    logic          update_en = 1'b0;
    logic [WL-1:0] update_way_idx = '0;
    logic          fill_en = 1'b0;
    logic [SL-1:0] fill_set = '0;
    logic [WL-1:0] fill_way_idx;

    always #5 clk = ~clk;

    cache_lru_tree #(
        .NUM_WAYS(NUM_WAYS),
        .NUM_SETS(NUM_SETS)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .init_done     (init_done),
        .access_en     (access_en),
        .access_set    (access_set),
        .update_en     (update_en),
        .update_way_idx(update_way_idx),
        .fill_en       (fill_en),
        .fill_set      (fill_set),
        .fill_way_idx  (fill_way_idx)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: the tree is walked as nested way ranges [lo,hi).
    logic [NODES-1:0] m_flags [NUM_SETS];
    logic [NODES-1:0] m_pend_flags;
    int               m_pend_set;
    bit               m_pend_fill;
    int               m_victim;

    function automatic int ref_victim(input logic [NODES-1:0] fl);
        int lo = 0;
        int hi = NUM_WAYS;
        int node = 0;
        while (hi - lo > 1) begin
            int mid;
            mid = (lo + hi) / 2;
            if (fl[node]) begin
                lo = mid; node = 2 * node + 2;
            end else begin
                hi = mid; node = 2 * node + 1;
            end
        end
        return lo;
    endfunction

    function automatic logic [NODES-1:0] ref_touch(input logic [NODES-1:0] fl, input int way);
        int lo = 0;
        int hi = NUM_WAYS;
        int node = 0;
        while (hi - lo > 1) begin
            int mid;
            mid = (lo + hi) / 2;
            if (way >= mid) begin
                fl[node] = 1'b0; lo = mid; node = 2 * node + 2;
            end else begin
                fl[node] = 1'b1; hi = mid; node = 2 * node + 1;
            end
        end
        return fl;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < NUM_SETS; s++) m_flags[s] = '0;
        m_pend_flags = '0;
        m_pend_set   = 0;
        m_pend_fill  = 1'b0;
        m_victim     = 0;
    endtask

    task automatic model_step(input bit acc, input int aset, input bit upd, input int uway,
                              input bit fil, input int fset, output bit rd, output int exp);
        bit               wr;
        int               way;
        int               set;
        logic [NODES-1:0] nf;
        logic [NODES-1:0] src;
        wr  = m_pend_fill || upd;
        way = m_pend_fill ? m_victim : uway;
        nf  = ref_touch(m_pend_flags, way);
        rd  = acc || fil;
        set = fil ? fset : aset;
        src = m_flags[set];
`ifdef CACHE_LRU_BYPASS_EN
        if (wr && set == m_pend_set) src = nf;
`endif
        if (wr) m_flags[m_pend_set] = nf;
        if (rd) begin
            m_pend_flags = src;
            m_pend_set   = set;
            m_victim     = ref_victim(src);
        end
        m_pend_fill = rd && fil;
        exp = m_victim;
    endtask

    // Drives one RUN cycle starting #1 after an edge; checks any lookup result.
    task automatic do_cycle(input bit acc, input int aset, input bit upd, input int uway,
                            input bit fil, input int fset, input string tag, output int got);
        bit rd;
        int exp;
        access_en      = acc;
        access_set     = SL'(aset);
        update_en      = upd;
        update_way_idx = WL'(uway);
        fill_en        = fil;
        fill_set       = SL'(fset);
        model_step(acc, aset, upd, uway, fil, fset, rd, exp);
        @(posedge clk);
        #1;
        got = int'(fill_way_idx);
        if (rd) check_eq(tag, fill_way_idx, exp);
    endtask

    task automatic idle();
        int g;
        do_cycle(0, 0, 0, 0, 0, 0, "idle", g);
    endtask

    // Counts edges from reset release to init_done while fill_en is held high.
    task automatic wait_init(input string tag);
        int n = 0;
        fill_en = 1'b1;
        while (!init_done && n < 100) begin
            fill_set = SL'($urandom_range(0, NUM_SETS - 1));
            @(posedge clk);
            n++;
            #1;
            check_eq({tag, "_way"}, fill_way_idx, 0);
        end
        fill_en = 1'b0;
        check_eq(tag, n, NUM_SETS);
        model_reset();
    endtask

    task automatic probe_all(input string tag);
        int g;
        for (int s = 0; s < NUM_SETS; s++) begin
            do_cycle(1, s, 0, 0, 0, 0, tag, g);
            check_eq({tag, "_zero"}, g, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int seq [4];
        int exp_seq [4];
        bit prev_rd;

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_init_done", init_done, 0);
        check_eq("rst_fill_way", fill_way_idx, 0);
        rst_n = 1'b1;
        wait_init("init_latency");
        check_eq("init_done_high", init_done, 1);
        probe_all("init_flags");

        // Back-to-back fills of one set.
`ifdef CACHE_LRU_BYPASS_EN
        exp_seq = '{0, 2, 1, 3};
`else
        exp_seq = '{0, 0, 2, 2};
`endif
        for (int i = 0; i < 4; i++) do_cycle(0, 0, 0, 0, 1, 3, "fill_b2b", seq[i]);
        idle();
        for (int i = 0; i < 4; i++) check_eq("fill_b2b_seq", seq[i], exp_seq[i]);

        // Fills separated by an idle cycle never hit the hazard.
        exp_seq = '{0, 2, 1, 3};
        for (int i = 0; i < 4; i++) begin
            do_cycle(0, 0, 0, 0, 1, 4, "fill_spaced", seq[i]);
            idle();
        end
        for (int i = 0; i < 4; i++) check_eq("fill_spaced_seq", seq[i], exp_seq[i]);

        // Hit touch of way 1 in set 5.
        do_cycle(1, 5, 0, 0, 0, 0, "hit_access", g);
        do_cycle(0, 0, 1, 1, 0, 0, "hit_update", g);
        do_cycle(0, 0, 0, 0, 1, 5, "hit_fill", g);
        check_eq("hit_victim", g, 2);
        idle();

        // Fill beats access; the following update is dropped.
        do_cycle(0, 0, 0, 0, 1, 7, "prio_prep", g);
        idle();
        do_cycle(1, 7, 0, 0, 1, 2, "prio_read", g);
        check_eq("prio_fill_set", g, 0);
        do_cycle(0, 0, 1, 2, 0, 0, "prio_upd", g);
        idle();
        do_cycle(1, 7, 0, 0, 0, 0, "prio_set7", g);
        check_eq("prio_set7_val", g, 2);
        do_cycle(1, 2, 0, 0, 0, 0, "prio_set2", g);
        check_eq("prio_set2_val", g, 2);
        idle();

        // Randomized traffic on a few sets to provoke same-set hazards.
        prev_rd = 1'b0;
        for (int i = 0; i < 400; i++) begin
            int r;
            bit acc;
            bit fil;
            bit upd;
            r   = int'($urandom_range(0, 9));
            fil = (r < 3);
            acc = (r >= 3 && r < 7);
            upd = prev_rd && ($urandom_range(0, 1) == 1);
            do_cycle(acc, int'($urandom_range(0, 3)), upd, int'($urandom_range(0, 3)),
                     fil, int'($urandom_range(0, 3)), "random", g);
            prev_rd = acc || fil;
        end
        idle();

        // Reset asserted in the middle of a fill.
        do_cycle(0, 0, 0, 0, 1, 9, "mid_prep", g);
        idle();
        do_cycle(0, 0, 0, 0, 1, 9, "mid_prep2", g);
        check_eq("mid_prep_way", g, 2);
        fill_en  = 1'b1;
        fill_set = SL'(9);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_done", init_done, 0);
        check_eq("mid_rst_way", fill_way_idx, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        wait_init("mid_init_latency");
        probe_all("mid_flags");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cache_lru_tree.md
CACHE_LRU_TREE -- requirements
Module: cache_lru_tree

Interface
REQ-001 SHALL have parameter NUM_WAYS, default 4, number of ways; a power of two, 2 to 64.
REQ-002 SHALL have parameter NUM_SETS, default 16, number of sets; a power of two, at least 2.
REQ-003 SHALL have derived parameters NUM_WAYS_LOG = $clog2(NUM_WAYS) and NUM_SETS_LOG = $clog2(NUM_SETS).
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-006 SHALL have port init_done, output, 1 bit, high once the flag array is cleared.
REQ-007 SHALL have port access_en, input, 1 bit, cycle-1 lookup read request.
REQ-008 SHALL have port access_set, input, NUM_SETS_LOG bits, lookup set.
REQ-009 SHALL have port update_en, input, 1 bit, cycle-2 hit touch for the previous-cycle access.
REQ-010 SHALL have port update_way_idx, input, NUM_WAYS_LOG bits, way that hit.
REQ-011 SHALL have port fill_en, input, 1 bit, cycle-1 victim request.
REQ-012 SHALL have port fill_set, input, NUM_SETS_LOG bits, set to fill.
REQ-013 SHALL have port fill_way_idx, output, NUM_WAYS_LOG bits, victim way, valid in cycle 2.

Function
REQ-014 SHALL keep per set NUM_WAYS-1 tree-PLRU flags in heap order: node n has children 2n+1 and 2n+2; leaf path bits select ways MSB first.
REQ-015 SHALL encode each flag as: 0 = LRU side is the left (lower-numbered) subtree, 1 = LRU side is the right subtree.
REQ-016 SHALL set fill_way_idx by walking from the root following the flags; walk uses the flags read in the previous cycle.
REQ-017 SHALL read in cycle N when access_en or fill_en is high; read set = fill_set if fill_en is high, else access_set.
REQ-018 SHALL write in cycle N+1 when a fill was read in cycle N or update_en is high; the new value is written at the end of cycle N+1.
REQ-019 SHALL select the touched way as fill_way_idx when the cycle-N read was a fill, else update_way_idx; fill wins when both apply.
REQ-020 SHALL, on a touch of way w, set every node on w's path to point away from w and leave all other nodes unchanged.
REQ-021 SHALL ignore update_en when the cycle-N read was a fill.
REQ-022 SHALL allow reads and writes in the same cycle; the read returns pre-write contents unless REQ-031 applies.
REQ-023 SHALL be implemented as a two-state FSM, INIT and RUN.
REQ-024 SHALL, in INIT, write all-zero flags to set counter 0..NUM_SETS-1, one set per cycle, then enter RUN.
REQ-025 SHALL, in INIT, hold init_done at 0, ignore access_en, fill_en and update_en, and drive fill_way_idx to 0.
REQ-026 SHALL, in RUN, hold init_done at 1 and never re-enter INIT except by reset.
REQ-027 SHALL wrap no counters in RUN; all set indices are taken modulo NUM_SETS by width.

Reset
REQ-028 SHALL, while rst_n is low, asynchronously force: state INIT, init counter 0, init_done 0, pending-fill flag 0, write set 0, fill_way_idx 0.
REQ-029 SHALL restart INIT from set 0 on any reset asserted mid-operation; a pending write is discarded.
REQ-030 SHALL assert init_done exactly NUM_SETS cycles after rst_n deasserts.

Configuration
REQ-031 SHALL, with macro CACHE_LRU_BYPASS_EN defined, forward the value being written to a same-cycle read of the same set, so back-to-back fills or touches to one set see current flags.
REQ-032 SHALL, without CACHE_LRU_BYPASS_EN, not forward; a same-set read during the write returns the stale pre-write flags, and no bypass logic is present.

Verification
REQ-033 SHALL check reset: release rst_n with NUM_SETS=16 -> init_done rises on cycle 16; fill_en is ignored before then; every set reads flags 000.
REQ-034 SHALL check fill order: NUM_WAYS=4, BYPASS_EN defined, fill set 3 on four consecutive cycles -> fill_way_idx sequence is 0, 2, 1, 3.
REQ-035 SHALL check stale read: same stimulus as REQ-034 without BYPASS_EN -> sequence 0, 0, 2, 2; with one idle cycle between fills -> 0, 2, 1, 3.
REQ-036 SHALL check hit update: access set 5, then update_en with way 1 -> the next fill of set 5 returns way 2.
REQ-037 SHALL check fill priority: fill_en on set 2 and access_en on set 7 in the same cycle -> set 2 is read; an update_en the next cycle is ignored and set 7 is unchanged.
REQ-038 SHALL check reset mid-operation: pulse rst_n low during a fill -> init_done drops, INIT reruns for NUM_SETS cycles, and all sets read 0.
